// File: rtl/key_debounce_array.sv
// N-channel push-button conditioner: per-key synchroniser, counter debounce,
// press/release pulses, long-press detection and optional auto-repeat.
module key_debounce_array #(
  parameter int N_KEYS       = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int LONG_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_in,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_press
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_REPEAT,
    S_HELD
  } hold_state_e;

  // Normalised so that 1 always means pressed from here on.
  logic [N_KEYS-1:0] pin_norm;
  assign pin_norm = ACTIVE_LOW ? ~i_in : i_in;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;
    hold_state_e            state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // NOTE: every default is assigned first so no path leaves a signal unassigned (no latches).
    always_comb begin
      db_cnt_d  = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync_s != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d   = ~level_q;
          press_d   = ~level_q;
          release_d = level_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // A release in the same cycle as a terminal count wins: the pulse is dropped.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      if (release_d) begin
        state_d    = S_IDLE;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (press_d) begin
              state_d    = S_PRESSED;
              hold_cnt_d = '0;
            end
          end
          S_PRESSED: begin
            if (hold_cnt_q == LONG_LAST) begin
              long_d     = 1'b1;
              hold_cnt_d = '0;
              state_d    = i_repeat_en[k] ? S_REPEAT : S_HELD;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          S_REPEAT: begin
            if (!i_repeat_en[k]) begin
              state_d    = S_HELD;
              hold_cnt_d = '0;
            end else if (hold_cnt_q == REPEAT_LAST) begin
              repeat_d   = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          S_HELD: begin
            hold_cnt_d = '0;
            if (i_repeat_en[k]) state_d = S_REPEAT;
          end
          default: begin
            state_d    = S_IDLE;
            hold_cnt_d = '0;
          end
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments only; the synchroniser
    // resets to the released value so reset never produces a phantom press.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync_q     <= '0;
        db_cnt_q   <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
        state_q    <= S_IDLE;
        hold_cnt_q <= '0;
      end else begin
        sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_norm[k]};
        db_cnt_q   <= db_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
      end
    end

    assign o_level[k]   = level_q;
    assign o_press[k]   = press_q;
    assign o_release[k] = release_q;
    assign o_long[k]    = long_q;
    assign o_repeat[k]  = repeat_q;
  end

  assign o_any_press = |o_press;

endmodule
